// File: rtl/console_uart_pkg.sv
// Shared constants for the console UART transmitter: register offsets,
// status bit layout, transmit FSM encoding and the status word builder.
package console_uart_pkg;

    localparam logic [31:0] OFS_DATA = 32'h0000_0000;
    localparam logic [31:0] OFS_STAT = 32'h0000_0004;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Assemble the status register; every unused bit reads as zero.
    function automatic logic [31:0] status_word(input logic busy, input logic full,
                                                input logic [7:0] count);
        logic [31:0] w;
        w                       = 32'h0000_0000;
        w[ST_BUSY]              = busy;
        w[ST_FULL]              = full;
        w[ST_COUNT_LSB +: 8]    = count;
        return w;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// Synchronous first-word-fall-through FIFO. A push is refused when full and a
// pop when empty; a simultaneous push and pop leaves the count unchanged.
module console_fifo
    import console_uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/console_uart_tx.sv
// Console output stage on the picorv32 native bus: byte writes to the data
// register are queued and sent as 8N1 frames; a full queue stalls the write.
module console_uart_tx
    import console_uart_pkg::*;
#(
    parameter logic [31:0] ADDR   = 32'h1000_0000,
    parameter int          DEPTH  = 16,
    parameter int          CLKDIV = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        ser_tx,
    output logic        tx_busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = $clog2(CLKDIV);
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLKDIV - 1);

    logic            hit_data_s;
    logic            hit_stat_s;
    logic            sel_s;
    logic            wr_byte_s;
    logic            ack_s;
    logic            push_s;
    logic            pop_s;
    logic            busy_s;
    logic [31:0]     rdata_next_s;
    logic [7:0]      fifo_dout_s;
    logic [CW-1:0]   fifo_count_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            unused_wdata_s;

    logic            mem_ready_r;
    logic [31:0]     mem_rdata_r;
    logic            ser_tx_r;
    logic            tx_busy_r;
    tx_state_e       state_r;
    logic [7:0]      shreg_r;
    logic [2:0]      bitn_r;
    logic [DW-1:0]   div_r;

    assign unused_wdata_s = ^mem_wdata[31:8];

    console_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_s),
        .din    (mem_wdata[7:0]),
        .pop    (pop_s),
        .dout   (fifo_dout_s),
        .count  (fifo_count_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

    // Bus decode: acknowledge once per request, holding off byte writes while full.
    always_comb begin
        hit_data_s   = (mem_addr == (ADDR + OFS_DATA));
        hit_stat_s   = (mem_addr == (ADDR + OFS_STAT));
        sel_s        = mem_valid && (hit_data_s || hit_stat_s);
        wr_byte_s    = hit_data_s && mem_wstrb[0];
        ack_s        = sel_s && !mem_ready_r && !(wr_byte_s && fifo_full_s);
        push_s       = ack_s && wr_byte_s;
        busy_s       = !fifo_empty_s || (state_r != TX_IDLE);
        if (ack_s && hit_stat_s && (mem_wstrb == 4'b0000)) begin
            rdata_next_s = status_word(busy_s, fifo_full_s, 8'(fifo_count_s));
        end else begin
            rdata_next_s = 32'h0000_0000;
        end
    end

    // Pop decision: take the next byte from IDLE, or chain straight on at the end of STOP.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            TX_IDLE: pop_s = !fifo_empty_s;
            TX_STOP: begin
                if (div_r == DW'(0)) begin
                    pop_s = !fifo_empty_s;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: pop_s = 1'b0;
        endcase
    end

    // Bus response registers and the busy flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_ready_r <= 1'b0;
            mem_rdata_r <= 32'h0000_0000;
            tx_busy_r   <= 1'b0;
        end else begin
            mem_ready_r <= ack_s;
            mem_rdata_r <= rdata_next_s;
            tx_busy_r   <= busy_s;
        end
    end

    // Frame serialiser: start bit, eight data bits LSB first, stop bit, CLKDIV cycles each.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= TX_IDLE;
            shreg_r  <= 8'h00;
            bitn_r   <= 3'd0;
            div_r    <= DW'(0);
            ser_tx_r <= 1'b1;
        end else begin
            case (state_r)
                TX_IDLE: begin
                    if (pop_s) begin
                        shreg_r  <= fifo_dout_s;
                        div_r    <= DIV_LOAD;
                        ser_tx_r <= 1'b0;
                        state_r  <= TX_START;
                    end
                end
                TX_START: begin
                    if (div_r == DW'(0)) begin
                        div_r    <= DIV_LOAD;
                        bitn_r   <= 3'd0;
                        ser_tx_r <= shreg_r[0];
                        state_r  <= TX_DATA;
                    end else begin
                        div_r <= div_r - DW'(1);
                    end
                end
                TX_DATA: begin
                    if (div_r == DW'(0)) begin
                        div_r   <= DIV_LOAD;
                        shreg_r <= {1'b0, shreg_r[7:1]};
                        if (bitn_r == 3'd7) begin
                            ser_tx_r <= 1'b1;
                            state_r  <= TX_STOP;
                        end else begin
                            bitn_r   <= bitn_r + 3'd1;
                            ser_tx_r <= shreg_r[1];
                        end
                    end else begin
                        div_r <= div_r - DW'(1);
                    end
                end
                TX_STOP: begin
                    if (div_r == DW'(0)) begin
                        if (pop_s) begin
                            shreg_r  <= fifo_dout_s;
                            div_r    <= DIV_LOAD;
                            ser_tx_r <= 1'b0;
                            state_r  <= TX_START;
                        end else begin
                            state_r  <= TX_IDLE;
                        end
                    end else begin
                        div_r <= div_r - DW'(1);
                    end
                end
                default: begin
                    state_r  <= TX_IDLE;
                    ser_tx_r <= 1'b1;
                end
            endcase
        end
    end

    assign mem_ready = mem_ready_r;
    assign mem_rdata = mem_rdata_r;
    assign ser_tx    = ser_tx_r;
    assign tx_busy   = tx_busy_r;

endmodule

// File: tb/tb_console_uart_tx.sv
// Scoreboard bench for console_uart_tx: accepted bytes are queued as expected
// frames and a line monitor decodes ser_tx and compares against the queue.
module tb_console_uart_tx;

    localparam int          CLKDIV = 4;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam int          FRAME  = 10 * CLKDIV;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        ser_tx;
    logic        tx_busy;

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    logic [7:0]  exp_q[$];
    int unsigned start_q[$];
    bit          mon_active = 1'b0;
    int          mon_pos = 0;
    logic [9:0]  mon_frame = 10'h3ff;

    console_uart_tx #(.ADDR(BASE), .DEPTH(DEPTH), .CLKDIV(CLKDIV)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .ser_tx    (ser_tx),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 'h%h, required 'h%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Line monitor: detects start bits, then checks every cycle of the frame.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (ser_tx === 1'b0) begin
                    start_q.push_back(cyc);
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_frame: got start bit at cycle %0d, required idle line", cyc);
                        mon_frame = 10'b1_0000_0000_0;
                    end else begin
                        b = exp_q.pop_front();
                        mon_frame = {1'b1, b, 1'b0};
                    end
                    mon_active = 1'b1;
                    mon_pos = 1;
                end
            end else begin
                check("ser_tx_bit", {31'h0, ser_tx}, {31'h0, mon_frame[mon_pos / CLKDIV]});
                mon_pos++;
                if (mon_pos == FRAME) mon_active = 1'b0;
            end
        end
    end

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int budget, output bit acked, output logic [31:0] rd,
                       output int waited);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        acked  = 1'b0;
        waited = 0;
        rd     = 32'h0;
        while (!acked && waited < budget) begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                acked = 1'b1;
                rd = mem_rdata;
            end else begin
                waited++;
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        if (acked && a == BASE && s[0]) exp_q.push_back(d[7:0]);
        @(negedge clk);
        if (acked) check("ready_single_cycle", {31'h0, mem_ready}, 32'h0);
    endtask

    task automatic write_byte(input logic [7:0] d, output int waited);
        bit acked;
        logic [31:0] rd;
        bus(BASE, {24'h0, d}, 4'b0001, 200, acked, rd, waited);
        check("write_ack", {31'h0, acked}, 32'h1);
    endtask

    task automatic read_status(input string name, input logic [31:0] req);
        bit acked;
        logic [31:0] rd;
        int w;
        bus(BASE + 32'h4, 32'h0, 4'b0000, 20, acked, rd, w);
        check({name, "_ack"}, {31'h0, acked}, 32'h1);
        check(name, rd, req);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((tx_busy !== 1'b0 || mon_active || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", {31'h0, (n >= budget)}, 32'h0);
    endtask

    initial begin
        int w;
        int idx;
        bit acked;
        logic [31:0] rd;
        logic [7:0] stall_bytes [6];
        stall_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

        // Reset state
        #12;
        check("rst_ser_tx", {31'h0, ser_tx}, 32'h1);
        check("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_tx_busy", {31'h0, tx_busy}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte: acknowledged at the first edge, one 40-cycle frame
        write_byte(8'h55, w);
        check("single_ack_latency", w, 0);
        wait_idle(200);
        check("single_busy_drop", {31'h0, tx_busy}, 32'h0);
        check("single_line_idle", {31'h0, ser_tx}, 32'h1);

        // Back-to-back: second start bit exactly one frame after the first
        idx = start_q.size();
        write_byte(8'h41, w);
        write_byte(8'h42, w);
        wait_idle(300);
        check("b2b_frames", start_q.size() - idx, 2);
        if (start_q.size() >= idx + 2)
            check("b2b_gap", start_q[idx+1] - start_q[idx], FRAME);

        // Full stall: five accepted at once, the sixth waits for the first chained pop
        for (int i = 0; i < 6; i++) begin
            write_byte(stall_bytes[i], w);
            if (i < 5) check("stall_early_ack", w, 0);
            else       check("stall_wait_cycles", w, 32);
        end
        wait_idle(600);

        // Status read with three queued bytes and a frame in flight
        for (int i = 0; i < 4; i++) write_byte(8'h61 + 8'(i), w);
        read_status("status_busy", 32'h0000_0301);
        bus(BASE, 32'h0, 4'b0000, 20, acked, rd, w);
        check("data_read_ack", {31'h0, acked}, 32'h1);
        check("data_read_zero", rd, 32'h0);
        wait_idle(400);
        read_status("status_drained", 32'h0);

        // Ignored traffic and non-byte-0 writes
        bus(BASE + 32'h8, 32'h77, 4'b0001, 8, acked, rd, w);
        check("ignore_off8", {31'h0, acked}, 32'h0);
        bus(32'h0001_0000, 32'h78, 4'b0001, 8, acked, rd, w);
        check("ignore_other", {31'h0, acked}, 32'h0);
        read_status("status_after_ignored", 32'h0);
        bus(BASE, 32'h99, 4'b0010, 20, acked, rd, w);
        check("wstrb1_ack", {31'h0, acked}, 32'h1);
        bus(BASE + 32'h4, 32'hFF, 4'b0001, 20, acked, rd, w);
        check("stat_write_ack", {31'h0, acked}, 32'h1);
        check("stat_write_rdata", rd, 32'h0);
        repeat (60) @(negedge clk);
        check("wstrb1_no_tx", {31'h0, tx_busy}, 32'h0);
        read_status("status_after_wstrb1", 32'h0);

        // Reset in the middle of data bit 3 with two bytes queued
        for (int i = 0; i < 3; i++) write_byte(8'hA1 + 8'(i), w);
        w = 0;
        while (!(mon_active && mon_pos >= 17 && mon_pos <= 19) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("reach_bit3_timeout", {31'h0, (w >= 100)}, 32'h0);
        #1 resetn = 1'b0;
        #1;
        check("midrst_ser_tx", {31'h0, ser_tx}, 32'h1);
        check("midrst_tx_busy", {31'h0, tx_busy}, 32'h0);
        check("midrst_mem_ready", {31'h0, mem_ready}, 32'h0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (60) @(negedge clk);
        check("postrst_line", {31'h0, ser_tx}, 32'h1);
        read_status("postrst_status", 32'h0);

        check("all_bytes_sent", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required completion before 1 ms");
        $fatal(1);
    end

endmodule
